// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

    // Transmitter FSM states, one per kind of serial bit.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Per-frame framing options, latched together with the data word.
    typedef struct packed {
        logic par_en;
        logic par_typ;
        logic stop2;
    } frame_cfg_t;

    // Line levels.
    localparam logic LVL_IDLE  = 1'b1;
    localparam logic LVL_START = 1'b0;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: even (par_typ_i=0) or odd (par_typ_i=1).
module uart_parity_calc #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              par_typ_i,
    output logic              par_o
);

    // Odd parity is the XNOR reduction, i.e. even parity inverted.
    assign par_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start / DATA_W data bits LSB first /
// optional parity / one or two stop bits, CLKS_PER_BIT clocks per bit.
// Define UART_TX_BUF_EN to add a one-word holding buffer so the source can
// hand over the next word while a frame is still on the line.
import uart_pkg::*;

module uart_tx_cfg #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              data_valid,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    output logic              ready,
    output logic              TX_OUT,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

    uart_state_e       state_q;
    logic [CW-1:0]     baud_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] data_q;
    frame_cfg_t        cfg_q;
    logic              par_q;
    logic              tx_q;

    frame_cfg_t        in_cfg;
    frame_cfg_t        ld_cfg;
    logic [DATA_W-1:0] ld_data;
    logic              ld_par;
    logic              accept;
    logic              start_frm;
    logic              bit_end;
    logic              last_stop;

    assign in_cfg    = '{par_en: PAR_EN, par_typ: PAR_TYP, stop2: STOP2};
    assign bit_end   = (baud_q == BAUD_LAST);
    // Final cycle of the final stop bit; bit_q counts stop bits in STOP.
    assign last_stop = (state_q == STOP) && bit_end &&
                       (!cfg_q.stop2 || (bit_q == BW'(1)));

`ifdef UART_TX_BUF_EN
    logic [DATA_W-1:0] buf_data_q;
    frame_cfg_t        buf_cfg_q;
    logic              buf_full_q;
    logic              buf_fill;

    assign ready   = !buf_full_q;
    assign accept  = data_valid && ready;
    // A full buffer always has priority over the input as the next frame.
    assign ld_data = buf_full_q ? buf_data_q : P_DATA;
    assign ld_cfg  = buf_full_q ? buf_cfg_q : in_cfg;
    assign start_frm = ((state_q == IDLE) && accept) ||
                       (last_stop && (buf_full_q || accept));
    // Words go straight to the frame registers when the line is free to take
    // them (idle, or stop end with empty buffer); otherwise they are parked.
    assign buf_fill = accept && (state_q != IDLE) && !(last_stop && !buf_full_q);
    assign busy     = (state_q != IDLE) || buf_full_q;

    // Holding register: fills on a parked accept, drains when a frame ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_q <= '0;
            buf_cfg_q  <= '0;
            buf_full_q <= 1'b0;
        end else if (buf_fill) begin
            buf_data_q <= P_DATA;
            buf_cfg_q  <= in_cfg;
            buf_full_q <= 1'b1;
        end else if (last_stop && buf_full_q) begin
            buf_full_q <= 1'b0;
        end
    end
`else
    assign ready     = (state_q == IDLE) || last_stop;
    assign accept    = data_valid && ready;
    assign ld_data   = P_DATA;
    assign ld_cfg    = in_cfg;
    assign start_frm = accept;
    assign busy      = (state_q != IDLE);
`endif

    // Parity is computed once on the word being loaded and kept with the frame.
    uart_parity_calc #(.DATA_W(DATA_W)) u_par (
        .data_i    (ld_data),
        .par_typ_i (ld_cfg.par_typ),
        .par_o     (ld_par)
    );

    assign TX_OUT = tx_q;

    // Frame FSM with baud/bit counters; TX_OUT is registered with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            cfg_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= LVL_IDLE;
        end else if (start_frm) begin
            state_q <= START;
            tx_q    <= LVL_START;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= ld_data;
            cfg_q   <= ld_cfg;
            par_q   <= ld_par;
        end else if (state_q == IDLE) begin
            baud_q <= '0;
            tx_q   <= LVL_IDLE;
        end else if (!bit_end) begin
            baud_q <= baud_q + 1'b1;
        end else begin
            baud_q <= '0;
            case (state_q)
                START: begin
                    state_q <= DATA;
                    bit_q   <= '0;
                    tx_q    <= data_q[0];
                end
                DATA: begin
                    if (bit_q == BIT_LAST) begin
                        bit_q <= '0;
                        if (cfg_q.par_en) begin
                            state_q <= PARITY;
                            tx_q    <= par_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= LVL_IDLE;
                        end
                    end else begin
                        bit_q  <= bit_q + 1'b1;
                        data_q <= data_q >> 1;
                        tx_q   <= data_q[1];
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    bit_q   <= '0;
                    tx_q    <= LVL_IDLE;
                end
                STOP: begin
                    if (cfg_q.stop2 && (bit_q == '0)) begin
                        bit_q <= BW'(1);
                    end else begin
                        state_q <= IDLE;
                        tx_q    <= LVL_IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= LVL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three instances cover default framing,
// a 4-clock bit period and a 7-bit data width.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0] d0;  logic v0, pe0, pt0, s20, rdy0, tx0, bsy0;
    logic [7:0] d1;  logic v1, pe1, pt1, s21, rdy1, tx1, bsy1;
    logic [6:0] d2;  logic v2, pe2, pt2, s22, rdy2, tx2, bsy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(1)) u0 (
        .clk(clk), .rst(rst), .P_DATA(d0), .data_valid(v0), .PAR_EN(pe0),
        .PAR_TYP(pt0), .STOP2(s20), .ready(rdy0), .TX_OUT(tx0), .busy(bsy0));

    uart_tx_cfg #(.DATA_W(8), .CLKS_PER_BIT(4)) u1 (
        .clk(clk), .rst(rst), .P_DATA(d1), .data_valid(v1), .PAR_EN(pe1),
        .PAR_TYP(pt1), .STOP2(s21), .ready(rdy1), .TX_OUT(tx1), .busy(bsy1));

    uart_tx_cfg #(.DATA_W(7), .CLKS_PER_BIT(1)) u2 (
        .clk(clk), .rst(rst), .P_DATA(d2), .data_valid(v2), .PAR_EN(pe2),
        .PAR_TYP(pt2), .STOP2(s22), .ready(rdy2), .TX_OUT(tx2), .busy(bsy2));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample/drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] ev;
        logic        er;

        d0 = '0; v0 = 0; pe0 = 0; pt0 = 0; s20 = 0;
        d1 = '0; v1 = 0; pe1 = 0; pt1 = 0; s21 = 0;
        d2 = '0; v2 = 0; pe2 = 0; pt2 = 0; s22 = 0;
        step();
        step();
        chk("rst_tx0", tx0, 1'b1);
        chk("rst_busy0", bsy0, 1'b0);
        chk("rst_ready0", rdy0, 1'b1);
        chk("rst_tx1", tx1, 1'b1);
        chk("rst_busy1", bsy1, 1'b0);
        chk("rst_tx2", tx2, 1'b1);
        rst = 1'b1;
        step();

        // 1: 0xF0, odd parity, one stop bit
        d0 = 8'hF0; pe0 = 1; pt0 = 1; s20 = 0; v0 = 1;
        step();
        v0 = 0;
        ev = {11'b00000111111, 53'b0};
        for (int i = 0; i < 11; i++) begin
`ifdef UART_TX_BUF_EN
            er = 1'b1;
`else
            er = (i == 10);
`endif
            chk("t1_tx", tx0, ev[63]);
            chk("t1_busy", bsy0, 1'b1);
            chk("t1_ready", rdy0, er);
            ev = ev << 1;
            step();
        end
        chk("t1_busy_end", bsy0, 1'b0);
        chk("t1_tx_end", tx0, 1'b1);

        // 2: back-to-back 0xF0 then 0x0F, second word in the final stop cycle
        d0 = 8'hF0; pe0 = 1; pt0 = 1; s20 = 0; v0 = 1;
        step();
        v0 = 0;
        ev = {11'b00000111111, 11'b01111000011, 42'b0};
        for (int i = 0; i < 22; i++) begin
            chk("t2_tx", tx0, ev[63]);
            chk("t2_busy", bsy0, 1'b1);
            if (i == 10) begin d0 = 8'h0F; v0 = 1; end
            if (i == 11) v0 = 0;
            ev = ev << 1;
            step();
        end
        chk("t2_busy_end", bsy0, 1'b0);

        // 3: CLKS_PER_BIT=4, no parity, two stop bits, 0xA5
        d1 = 8'hA5; pe1 = 0; pt1 = 0; s21 = 1; v1 = 1;
        step();
        v1 = 0;
        ev = {11'b01010010111, 53'b0};
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 4; c++) begin
                chk("t3_tx", tx1, ev[63]);
                chk("t3_busy", bsy1, 1'b1);
                step();
            end
            ev = ev << 1;
        end
        chk("t3_busy_end", bsy1, 1'b0);
        chk("t3_tx_end", tx1, 1'b1);

        // 4: DATA_W=7, even parity, 0x55
        d2 = 7'h55; pe2 = 1; pt2 = 0; s22 = 0; v2 = 1;
        step();
        v2 = 0;
        ev = {10'b0101010101, 54'b0};
        for (int i = 0; i < 10; i++) begin
            chk("t4_tx", tx2, ev[63]);
            chk("t4_busy", bsy2, 1'b1);
            ev = ev << 1;
            step();
        end
        chk("t4_busy_end", bsy2, 1'b0);

        // 5: asynchronous reset in the middle of the data bits
        d0 = 8'hF0; pe0 = 0; pt0 = 0; s20 = 0; v0 = 1;
        step();
        v0 = 0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_pre_tx", tx0, 1'b0);
        chk("t5_pre_busy", bsy0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_tx", tx0, 1'b1);
        chk("t5_rst_busy", bsy0, 1'b0);
        chk("t5_rst_ready", rdy0, 1'b1);
        #2 rst = 1'b1;
        step();
        d0 = 8'h0F; pe0 = 0; pt0 = 0; s20 = 1; v0 = 1;
        step();
        v0 = 0;
        ev = {11'b01111000011, 53'b0};
        for (int i = 0; i < 11; i++) begin
            chk("t5_tx", tx0, ev[63]);
            chk("t5_busy", bsy0, 1'b1);
            ev = ev << 1;
            step();
        end
        chk("t5_busy_end", bsy0, 1'b0);

`ifdef UART_TX_BUF_EN
        // 6: three words on consecutive cycles; third one is dropped
        d0 = 8'h81; pe0 = 0; pt0 = 0; s20 = 0; v0 = 1;
        step();
        ev = {10'b0100000011, 10'b0001111001, 44'b0};
        for (int i = 0; i < 20; i++) begin
            chk("t6_tx", tx0, ev[63]);
            chk("t6_busy", bsy0, 1'b1);
            if (i == 0) begin chk("t6_rdy_w2", rdy0, 1'b1); d0 = 8'h3C; end
            if (i == 1) begin chk("t6_rdy_w3", rdy0, 1'b0); d0 = 8'hFF; end
            if (i == 2) v0 = 0;
            if (i == 9) chk("t6_rdy_full", rdy0, 1'b0);
            if (i == 10) chk("t6_rdy_drained", rdy0, 1'b1);
            ev = ev << 1;
            step();
        end
        chk("t6_busy_end", bsy0, 1'b0);
        chk("t6_tx_end", tx0, 1'b1);
`else
        // 6: a word offered while ready is low is not stored
        d0 = 8'h81; pe0 = 0; pt0 = 0; s20 = 0; v0 = 1;
        step();
        v0 = 0;
        ev = {10'b0100000011, 54'b0};
        for (int i = 0; i < 10; i++) begin
            chk("t6_tx", tx0, ev[63]);
            chk("t6_busy", bsy0, 1'b1);
            if (i == 3) begin chk("t6_rdy_low", rdy0, 1'b0); d0 = 8'hFF; v0 = 1; end
            if (i == 4) v0 = 0;
            ev = ev << 1;
            step();
        end
        chk("t6_busy_end", bsy0, 1'b0);
        chk("t6_tx_end", tx0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
